dspi_request_scheduler: RTL and testbench



---
 rtl/dspi_request_scheduler.sv | 112 +++++++++++
 tb/tb_dspi_request_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dspi_request_scheduler.sv
// dspi_request_scheduler: round-robin instruction arbiter for one DSPI stream with
// per-requester outstanding-packet tracking and REQUEST throttling.
module dspi_request_scheduler #(
    parameter int NUM_REQ                     = 4,
    parameter int STREAM_ID                   = 0,
    parameter int STREAM_ID_NUM               = 16,
    parameter int CHANNEL_ID_NUM              = 1024,
    parameter int INSTRUCTION_WIDTH           = 2,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter int INSTRUCTION_CMD_IDLE        = 0,
    parameter int INSTRUCTION_CMD_REQUEST     = 1,
    parameter int INSTRUCTION_CMD_REWIND      = 2,
    parameter int INSTRUCTION_CMD_RESET       = 3,
    parameter int MAX_OUTSTANDING             = 64,
    localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
    localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req_valid,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic [NUM_REQ*INSTRUCTION_WIDTH-1:0]            req_cmd,
    input  logic [NUM_REQ*CHANNEL_ID_WIDTH-1:0]             req_channel,
    input  logic [NUM_REQ*INSTRUCTION_PARAMETER_WIDTH-1:0]  req_param,
    input  logic [1:0]                                      Front_Type,
    input  logic                                            Front_Last,
    input  logic [STREAM_ID_WIDTH-1:0]                      Front_StreamID,
    input  logic [CHANNEL_ID_WIDTH-1:0]                     Front_ChannelID,
    output logic [INSTRUCTION_WIDTH-1:0]                    Front_InstructionType,
    output logic [STREAM_ID_WIDTH-1:0]                      Front_InstructionStreamID,
    output logic [CHANNEL_ID_WIDTH-1:0]                     Front_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0]          Front_InstructionParameter,
    output logic [NUM_REQ-1:0]                              outstanding_zero
);
    localparam int IW = INSTRUCTION_WIDTH;
    localparam int PW = INSTRUCTION_PARAMETER_WIDTH;
    localparam int CW = CHANNEL_ID_WIDTH;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((OW > PW) ? OW : PW) + 1;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] CMD_IDLE    = IW'(INSTRUCTION_CMD_IDLE);
    localparam logic [IW-1:0] CMD_REQUEST = IW'(INSTRUCTION_CMD_REQUEST);
    localparam logic [IW-1:0] CMD_RESET   = IW'(INSTRUCTION_CMD_RESET);

    logic [OW-1:0]      outstanding [NUM_REQ];
    logic [OW-1:0]      out_nxt [NUM_REQ];
    logic [GW-1:0]      rr_ptr, gidx;
    logic               gnt;
    logic [NUM_REQ-1:0] elig, ret;

    // Sums are widened so outstanding + param can never wrap before the cap compare.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (req_cmd[i*IW +: IW] != CMD_REQUEST ||
                      SW'(outstanding[i]) + SW'(req_param[i*PW +: PW]) <= SW'(MAX_OUTSTANDING));
            ret[i]  = Front_Type[0] && Front_Last && Front_StreamID == STREAM_ID_WIDTH'(STREAM_ID) &&
                      Front_ChannelID == req_channel[i*CW +: CW];
        end
    end

    // Scan from the far end so the last hit is the one closest to rr_ptr.
    always_comb begin
        gnt  = 1'b0;
        gidx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt  = 1'b1;
                gidx = GW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = !rst && gnt && gidx == GW'(i);
    end

    always_comb begin
        logic [SW-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = SW'(outstanding[i]) +
                  ((req_ready[i] && req_cmd[i*IW +: IW] == CMD_REQUEST) ? SW'(req_param[i*PW +: PW]) : '0);
            out_nxt[i] = (req_ready[i] && req_cmd[i*IW +: IW] == CMD_RESET) ? '0 :
                         OW'(sum - SW'(ret[i] && sum != '0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr                     <= '0;
            outstanding_zero           <= '1;
            Front_InstructionType      <= CMD_IDLE;
            Front_InstructionStreamID  <= '0;
            Front_InstructionChannelID <= '0;
            Front_InstructionParameter <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i]      <= out_nxt[i];
                outstanding_zero[i] <= out_nxt[i] == '0;
            end
            if (gnt)
                rr_ptr <= (gidx == GW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            Front_InstructionType      <= gnt ? req_cmd[gidx*IW +: IW] : CMD_IDLE;
            Front_InstructionStreamID  <= gnt ? STREAM_ID_WIDTH'(STREAM_ID) : '0;
            Front_InstructionChannelID <= gnt ? req_channel[gidx*CW +: CW] : '0;
            Front_InstructionParameter <= gnt ? req_param[gidx*PW +: PW] : '0;
        end
    end
endmodule

// File: tb/tb_dspi_request_scheduler.sv
// tb_dspi_request_scheduler: directed vector table plus hand sequences for cap,
// simultaneous update, return filtering and command handling.
module tb_dspi_request_scheduler;
    localparam logic [39:0] CHANS = {10'd40, 10'd30, 10'd20, 10'd10};
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, REW = 2'd2, RST = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  valid, ready, oz;
    logic [1:0]  cmd [4];
    logic [15:0] prm [4];
    logic [7:0]  req_cmd;
    logic [63:0] req_param;
    logic [1:0]  f_type, i_type;
    logic        f_last;
    logic [3:0]  f_sid, i_sid;
    logic [9:0]  f_ch, i_ch;
    logic [15:0] i_prm;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_cmd   = '0;
        req_param = '0;
        for (int i = 0; i < 4; i++) begin
            req_cmd[i*2 +: 2]    = cmd[i];
            req_param[i*16 +: 16] = prm[i];
        end
    end

    dspi_request_scheduler #(.STREAM_ID(5)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready), .req_cmd(req_cmd),
        .req_channel(CHANS), .req_param(req_param), .Front_Type(f_type), .Front_Last(f_last),
        .Front_StreamID(f_sid), .Front_ChannelID(f_ch), .Front_InstructionType(i_type),
        .Front_InstructionStreamID(i_sid), .Front_InstructionChannelID(i_ch),
        .Front_InstructionParameter(i_prm), .outstanding_zero(oz)
    );

    typedef struct {
        logic [3:0]  v;
        logic [1:0]  c;
        logic [15:0] p;
        logic [3:0]  rdy;
        logic [9:0]  ch;
        logic [3:0]  oz;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_ready(input string nm, input logic [3:0] exp);
        #1;
        chk(nm, 32'(ready), 32'(exp));
    endtask

    task automatic issue(input string nm, input logic [1:0] t, input logic [9:0] ch, input logic [15:0] p);
        chk({nm, "_type"}, 32'(i_type), 32'(t));
        if (t != IDLE) begin
            chk({nm, "_sid"}, 32'(i_sid), 32'd5);
            chk({nm, "_ch"}, 32'(i_ch), 32'(ch));
            chk({nm, "_prm"}, 32'(i_prm), 32'(p));
        end
    endtask

    task automatic only(input int i, input logic [1:0] c, input logic [15:0] p);
        valid    = '0;
        valid[i] = 1'b1;
        cmd[i]   = c;
        prm[i]   = p;
    endtask

    task automatic front(input logic [1:0] t, input logic l, input logic [3:0] s, input logic [9:0] ch);
        f_type = t;
        f_last = l;
        f_sid  = s;
        f_ch   = ch;
    endtask

    initial begin
        tbl[0] = '{4'b1111, REQ, 16'd1,  4'b0001, 10'd10, 4'b1110};
        tbl[1] = '{4'b1111, REQ, 16'd1,  4'b0010, 10'd20, 4'b1100};
        tbl[2] = '{4'b1111, REQ, 16'd1,  4'b0100, 10'd30, 4'b1000};
        tbl[3] = '{4'b1111, REQ, 16'd1,  4'b1000, 10'd40, 4'b0000};
        tbl[4] = '{4'b1111, REQ, 16'd1,  4'b0001, 10'd10, 4'b0000};
        tbl[5] = '{4'b1001, REQ, 16'd1,  4'b1000, 10'd40, 4'b0000};
        tbl[6] = '{4'b0110, REQ, 16'd1,  4'b0010, 10'd20, 4'b0000};
        tbl[7] = '{4'b0000, REQ, 16'd1,  4'b0000, 10'd0,  4'b0000};
        tbl[8] = '{4'b0011, REQ, 16'd1,  4'b0001, 10'd10, 4'b0000};
        tbl[9] = '{4'b0011, REW, 16'd12, 4'b0010, 10'd20, 4'b0000};

        front(2'b00, 1'b0, 4'd0, 10'd0);
        valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cmd[i] = REQ;
            prm[i] = 16'd1;
        end
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_type", 32'(i_type), 32'd0);
        chk("rst_oz", 32'(oz), 32'hF);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) begin
            valid = tbl[n].v;
            for (int i = 0; i < 4; i++) begin
                cmd[i] = tbl[n].c;
                prm[i] = tbl[n].p;
            end
            settle_ready($sformatf("vec%0d_ready", n), tbl[n].rdy);
            tick();
            issue($sformatf("vec%0d", n), (tbl[n].rdy != 0) ? tbl[n].c : IDLE, tbl[n].ch, tbl[n].p);
            chk($sformatf("vec%0d_oz", n), 32'(oz), 32'(tbl[n].oz));
        end

        valid = 4'hF;
        rst = 1'b1;
        settle_ready("midrst_ready", 4'b0000);
        tick();
        chk("midrst_type", 32'(i_type), 32'd0);
        chk("midrst_ch", 32'(i_ch), 32'd0);
        chk("midrst_prm", 32'(i_prm), 32'd0);
        chk("midrst_sid", 32'(i_sid), 32'd0);
        chk("midrst_oz", 32'(oz), 32'hF);
        rst = 1'b0;
        only(0, REQ, 16'd8);
        settle_ready("first_ready", 4'b0001);
        tick();
        issue("first", REQ, 10'd10, 16'd8);
        valid = '0;
        tick();
        chk("hold_one_type", 32'(i_type), 32'd0);

        only(1, REQ, 16'd60);
        settle_ready("cap60_ready", 4'b0010);
        tick();
        issue("cap60", REQ, 10'd20, 16'd60);
        only(1, REQ, 16'd8);
        settle_ready("cap_block_ready", 4'b0000);
        tick();
        front(2'b01, 1'b1, 4'd5, 10'd20);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("cap_ret%0d_ready", n), 32'(ready), 32'd0);
            tick();
        end
        front(2'b00, 1'b0, 4'd0, 10'd0);
        settle_ready("cap_open_ready", 4'b0010);
        tick();
        issue("cap8", REQ, 10'd20, 16'd8);
        chk("cap_oz", 32'(oz), 32'b1100);

        only(2, REQ, 16'd5);
        settle_ready("sim5_ready", 4'b0100);
        tick();
        issue("sim5", REQ, 10'd30, 16'd5);
        only(2, REQ, 16'd3);
        front(2'b01, 1'b1, 4'd5, 10'd30);
        settle_ready("sim3_ready", 4'b0100);
        tick();
        issue("sim3", REQ, 10'd30, 16'd3);
        front(2'b00, 1'b0, 4'd0, 10'd0);
        only(2, REQ, 16'd58);
        settle_ready("sim7_58_ready", 4'b0000);
        prm[2] = 16'd57;
        settle_ready("sim7_57_ready", 4'b0100);
        tick();
        issue("sim57", REQ, 10'd30, 16'd57);
        chk("sim57_oz", 32'(oz), 32'b1000);
        only(2, RST, 16'd9);
        front(2'b01, 1'b1, 4'd5, 10'd30);
        settle_ready("reset_ready", 4'b0100);
        tick();
        issue("reset", RST, 10'd30, 16'd9);
        front(2'b00, 1'b0, 4'd0, 10'd0);
        chk("reset_oz", 32'(oz), 32'b1100);

        only(3, REQ, 16'd2);
        settle_ready("flt2_ready", 4'b1000);
        tick();
        issue("flt2", REQ, 10'd40, 16'd2);
        valid = '0;
        front(2'b10, 1'b1, 4'd5, 10'd40);
        tick();
        front(2'b01, 1'b0, 4'd5, 10'd40);
        tick();
        front(2'b01, 1'b1, 4'd4, 10'd40);
        tick();
        front(2'b01, 1'b1, 4'd5, 10'd30);
        tick();
        front(2'b00, 1'b0, 4'd0, 10'd0);
        chk("flt_oz", 32'(oz), 32'b0100);
        only(3, REQ, 16'd63);
        settle_ready("flt63_ready", 4'b0000);
        prm[3] = 16'd62;
        settle_ready("flt62_ready", 4'b1000);
        tick();
        issue("flt62", REQ, 10'd40, 16'd62);
        only(2, REQ, 16'd64);
        settle_ready("nounder_ready", 4'b0100);
        tick();
        issue("nounder", REQ, 10'd30, 16'd64);

        only(0, REW, 16'd12);
        settle_ready("rewind_ready", 4'b0001);
        tick();
        issue("rewind", REW, 10'd10, 16'd12);
        only(0, REQ, 16'd57);
        settle_ready("rew57_ready", 4'b0000);
        prm[0] = 16'd56;
        settle_ready("rew56_ready", 4'b0001);
        tick();
        issue("rew56", REQ, 10'd10, 16'd56);
        only(1, IDLE, 16'd5);
        settle_ready("idle_ready", 4'b0010);
        tick();
        chk("idle_type", 32'(i_type), 32'd0);
        valid = '0;
        tick();
        chk("final_oz", 32'(oz), 32'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
